// File: rtl/aesl_deadlock_report_ctrl_if.sv
// Bundles the monitor inputs, the report record stream and the deadlock status of the report controller.
// master = controller side, slave = monitor/reporter side.
interface aesl_deadlock_report_ctrl_if #(
  parameter int NCH     = 3,
  parameter int FIELD_W = 3,
  parameter int CNT_W   = 16
);
  localparam int CHAN_W = $clog2(NCH) + 1;

  logic                     block;
  logic [NCH*FIELD_W-1:0]   axis_block_info;
  logic                     rpt_valid;
  logic                     rpt_ready;
  logic [CHAN_W-1:0]        rpt_chan;
  logic [FIELD_W-1:0]       rpt_field;
  logic                     deadlock_found;
  logic                     finish_req;
  logic [CNT_W-1:0]         persist_cnt;

  modport master (
    input  block, axis_block_info, rpt_ready,
    output rpt_valid, rpt_chan, rpt_field, deadlock_found, finish_req, persist_cnt
  );

  modport slave (
    output block, axis_block_info, rpt_ready,
    input  rpt_valid, rpt_chan, rpt_field, deadlock_found, finish_req, persist_cnt
  );
endinterface

// File: rtl/aesl_deadlock_report_ctrl.sv
// Declares deadlock after THRESHOLD stable blocked cycles, then streams one record per blocked channel.
// All outputs registered; rpt_valid is computed from next state, never from rpt_ready in the same cycle.
module aesl_deadlock_report_ctrl #(
  parameter int NCH       = 3,
  parameter int FIELD_W   = 3,
  parameter int THRESHOLD = 1000,
  parameter int CNT_W     = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  aesl_deadlock_report_ctrl_if.master   bus
);
  localparam int CHAN_W = $clog2(NCH) + 1;
  localparam int INFO_W = NCH * FIELD_W;
  localparam logic [CNT_W-1:0]  THR_CNT = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0]  THR_M1  = CNT_W'(THRESHOLD - 1);
  localparam logic [CHAN_W-1:0] LAST_CH = CHAN_W'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SUSPECT, S_DUMP, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_persist_cnt, w_persist_nxt;
  logic [INFO_W-1:0]   r_info_hold, w_info_hold_nxt;
  logic [INFO_W-1:0]   r_snapshot, w_snapshot_nxt;
  logic [CHAN_W-1:0]   r_ptr, w_ptr_nxt;
  logic                r_rpt_valid, w_rpt_valid_nxt;
  logic [CHAN_W-1:0]   r_rpt_chan, w_rpt_chan_nxt;
  logic [FIELD_W-1:0]  r_rpt_field, w_rpt_field_nxt;
  logic                r_deadlock_found, w_found_nxt;
  logic                r_finish_req, w_finish_nxt;
  logic [FIELD_W-1:0]  w_cur_field;
  logic [FIELD_W-1:0]  w_nxt_field;
  logic                w_handled;

  function automatic logic [FIELD_W-1:0] f_field(input logic [INFO_W-1:0] v,
                                                 input logic [CHAN_W-1:0] p);
    logic [FIELD_W-1:0] f;
    f = '0;
    for (int k = 0; k < NCH; k++) begin
      if (p == CHAN_W'(k)) f = v[k*FIELD_W +: FIELD_W];
    end
    return f;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_persist_cnt    <= '0;
      r_info_hold      <= '0;
      r_snapshot       <= '0;
      r_ptr            <= '0;
      r_rpt_valid      <= 1'b0;
      r_rpt_chan       <= '0;
      r_rpt_field      <= '0;
      r_deadlock_found <= 1'b0;
      r_finish_req     <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_persist_cnt    <= w_persist_nxt;
      r_info_hold      <= w_info_hold_nxt;
      r_snapshot       <= w_snapshot_nxt;
      r_ptr            <= w_ptr_nxt;
      r_rpt_valid      <= w_rpt_valid_nxt;
      r_rpt_chan       <= w_rpt_chan_nxt;
      r_rpt_field      <= w_rpt_field_nxt;
      r_deadlock_found <= w_found_nxt;
      r_finish_req     <= w_finish_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_persist_nxt   = r_persist_cnt;
    w_info_hold_nxt = r_info_hold;
    w_snapshot_nxt  = r_snapshot;
    w_ptr_nxt       = r_ptr;
    w_cur_field     = f_field(r_snapshot, r_ptr);
    // A zero field is skipped; a non-zero one waits for its handshake.
    w_handled       = (w_cur_field == '0) || (r_rpt_valid && bus.rpt_ready);
    unique case (r_state)
      S_IDLE: begin
        if (bus.block) begin
          w_info_hold_nxt = bus.axis_block_info;
          w_persist_nxt   = CNT_W'(1);
          if (THRESHOLD == 1) begin
            w_state_nxt    = S_DUMP;
            w_snapshot_nxt = bus.axis_block_info;
            w_ptr_nxt      = '0;
          end else begin
            w_state_nxt    = S_SUSPECT;
          end
        end
      end
      S_SUSPECT: begin
        if (!bus.block) begin
          w_state_nxt   = S_IDLE;
          w_persist_nxt = '0;
        end else if (bus.axis_block_info != r_info_hold) begin
          w_info_hold_nxt = bus.axis_block_info;
          w_persist_nxt   = CNT_W'(1);
        end else if (r_persist_cnt == THR_M1) begin
          w_state_nxt    = S_DUMP;
          w_snapshot_nxt = r_info_hold;
          w_persist_nxt  = THR_CNT;
          w_ptr_nxt      = '0;
        end else begin
          w_persist_nxt = r_persist_cnt + 1'b1;
        end
      end
      S_DUMP: begin
        if (w_handled) begin
          if (r_ptr == LAST_CH) w_state_nxt = S_DONE;
          else                  w_ptr_nxt   = r_ptr + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_nxt_field     = f_field(w_snapshot_nxt, w_ptr_nxt);
    w_rpt_valid_nxt = (w_state_nxt == S_DUMP) && (w_nxt_field != '0);
    w_rpt_chan_nxt  = w_rpt_valid_nxt ? w_ptr_nxt : '0;
    w_rpt_field_nxt = w_rpt_valid_nxt ? w_nxt_field : '0;
    w_found_nxt     = (w_state_nxt == S_DONE);
    w_finish_nxt    = (w_state_nxt == S_DONE) && (r_state != S_DONE);
  end

  assign bus.rpt_valid      = r_rpt_valid;
  assign bus.rpt_chan       = r_rpt_chan;
  assign bus.rpt_field      = r_rpt_field;
  assign bus.deadlock_found = r_deadlock_found;
  assign bus.finish_req     = r_finish_req;
  assign bus.persist_cnt    = r_persist_cnt;
endmodule

// File: tb/tb_aesl_deadlock_report_ctrl.sv
// Bench for the deadlock report controller: THRESHOLD=8 and THRESHOLD=1 instances,
// directed sequences, a vector table and random stimulus against a reference model.
module tb_aesl_deadlock_report_ctrl;
  localparam int NCH = 3;
  localparam int FW  = 3;
  localparam int CW  = 16;

  logic clock = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  aesl_deadlock_report_ctrl_if #(.NCH(NCH), .FIELD_W(FW), .CNT_W(CW)) if8 ();
  aesl_deadlock_report_ctrl_if #(.NCH(NCH), .FIELD_W(FW), .CNT_W(CW)) if1 ();

  aesl_deadlock_report_ctrl #(.NCH(NCH), .FIELD_W(FW), .THRESHOLD(8), .CNT_W(CW)) u_dut8 (
    .clock(clock), .reset(reset), .bus(if8.master));
  aesl_deadlock_report_ctrl #(.NCH(NCH), .FIELD_W(FW), .THRESHOLD(1), .CNT_W(CW)) u_dut1 (
    .clock(clock), .reset(reset), .bus(if1.master));

  typedef struct {
    bit         blk;
    logic [8:0] info;
    bit         rdy;
    bit         ev;
    int         ech;
    int         efl;
    bit         efd;
    bit         efn;
    int         ecnt;
  } vec_t;
  vec_t tbl[11];

  // Reference model: 0 = watching, 1 = reporting, 2 = finished
  int         m_phase[2];
  int         m_run[2];
  logic [8:0] m_last[2];
  logic [8:0] m_snap[2];
  int         m_next[2];
  bit         m_first[2];
  int         thr[2];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(int d, bit b, logic [8:0] inf, bit r);
    if (d == 0) begin
      if8.block = b; if8.axis_block_info = inf; if8.rpt_ready = r;
    end else begin
      if1.block = b; if1.axis_block_info = inf; if1.rpt_ready = r;
    end
  endtask

  task automatic chk_out(int d, string tag, bit ev, int ech, int efl, bit efd, bit efn, int ecnt);
    logic [31:0] v, ch, fl, fd, fn, cn;
    if (d == 0) begin
      v = 32'(if8.rpt_valid); ch = 32'(if8.rpt_chan); fl = 32'(if8.rpt_field);
      fd = 32'(if8.deadlock_found); fn = 32'(if8.finish_req); cn = 32'(if8.persist_cnt);
    end else begin
      v = 32'(if1.rpt_valid); ch = 32'(if1.rpt_chan); fl = 32'(if1.rpt_field);
      fd = 32'(if1.deadlock_found); fn = 32'(if1.finish_req); cn = 32'(if1.persist_cnt);
    end
    chk({tag, ".valid"}, v, 32'(ev));
    if (ev) begin
      chk({tag, ".chan"}, ch, 32'(ech));
      chk({tag, ".field"}, fl, 32'(efl));
    end
    chk({tag, ".found"}, fd, 32'(efd));
    chk({tag, ".finish"}, fn, 32'(efn));
    chk({tag, ".cnt"}, cn, 32'(ecnt));
  endtask

  task automatic chk_zero(int d, string tag);
    chk_out(d, tag, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    chk({tag, ".chan0"}, 32'(d == 0 ? if8.rpt_chan : if1.rpt_chan), 32'd0);
    chk({tag, ".field0"}, 32'(d == 0 ? if8.rpt_field : if1.rpt_field), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv(0, 1'b0, 9'h0, 1'b0);
    drv(1, 1'b0, 9'h0, 1'b0);
    step();
    reset = 1'b0;
  endtask

  function automatic int fld(logic [8:0] v, int k);
    logic [8:0] s;
    s = v >> (3 * k);
    return int'(s[2:0]);
  endfunction

  function automatic logic [8:0] rand_info();
    logic [8:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) begin
      if ($urandom_range(0, 1) == 1) r = r | (9'(($urandom_range(1, 7))) << (3 * k));
    end
    return r;
  endfunction

  function automatic bit m_ev(int d);
    return (m_phase[d] == 1) && (fld(m_snap[d], m_next[d]) != 0);
  endfunction

  task automatic m_reset(int d);
    m_phase[d] = 0; m_run[d] = 0; m_last[d] = '0; m_snap[d] = '0; m_next[d] = 0; m_first[d] = 1'b0;
  endtask

  task automatic m_step(int d, bit blk, logic [8:0] info, bit rdy, bit rst);
    bit v;
    if (rst) begin
      m_reset(d);
      return;
    end
    v = m_ev(d);
    case (m_phase[d])
      0: begin
        if (blk) begin
          if (m_run[d] > 0 && info == m_last[d]) m_run[d]++;
          else m_run[d] = 1;
          m_last[d] = info;
          if (m_run[d] == thr[d]) begin
            m_phase[d] = 1; m_snap[d] = info; m_next[d] = 0;
          end
        end else begin
          m_run[d] = 0;
        end
      end
      1: begin
        if (fld(m_snap[d], m_next[d]) == 0 || (v && rdy)) begin
          m_next[d]++;
          if (m_next[d] == NCH) begin
            m_phase[d] = 2; m_first[d] = 1'b1;
          end
        end
      end
      default: m_first[d] = 1'b0;
    endcase
  endtask

  task automatic m_check(int d, string tag);
    chk_out(d, tag, m_ev(d), m_next[d], fld(m_snap[d], m_next[d]),
            m_phase[d] == 2, m_phase[d] == 2 && m_first[d],
            m_phase[d] == 0 ? m_run[d] : thr[d]);
  endtask

  initial begin
    logic [8:0] cur_info;
    bit blk, rst, r0, r1;

    thr[0] = 8;
    thr[1] = 1;
    tbl[0]  = '{1'b1, 9'h1C0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1};
    tbl[1]  = '{1'b0, 9'h000, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1};
    tbl[2]  = '{1'b0, 9'h000, 1'b0, 1'b1, 2, 7, 1'b0, 1'b0, 1};
    tbl[3]  = '{1'b1, 9'h1FF, 1'b0, 1'b1, 2, 7, 1'b0, 1'b0, 1};
    tbl[4]  = '{1'b0, 9'h000, 1'b0, 1'b1, 2, 7, 1'b0, 1'b0, 1};
    tbl[5]  = '{1'b1, 9'h049, 1'b0, 1'b1, 2, 7, 1'b0, 1'b0, 1};
    tbl[6]  = '{1'b0, 9'h000, 1'b0, 1'b1, 2, 7, 1'b0, 1'b0, 1};
    tbl[7]  = '{1'b0, 9'h000, 1'b0, 1'b1, 2, 7, 1'b0, 1'b0, 1};
    tbl[8]  = '{1'b0, 9'h000, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1};
    tbl[9]  = '{1'b1, 9'h1FF, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1};
    tbl[10] = '{1'b0, 9'h000, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1};

    reset = 1'b1;
    drv(0, 1'b0, 9'h0, 1'b0);
    drv(1, 1'b0, 9'h0, 1'b0);
    step();
    step();
    chk_zero(0, "rst8");
    chk_zero(1, "rst1");
    reset = 1'b0;

    // T1: short block burst never declares
    do_reset();
    drv(0, 1'b1, 9'h0A5, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_out(0, $sformatf("t1_c%0d", k), 1'b0, 0, 0, 1'b0, 1'b0, k);
    end
    drv(0, 1'b0, 9'h0A5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out(0, $sformatf("t1_drop%0d", k), 1'b0, 0, 0, 1'b0, 1'b0, 0);
    end

    // T2: stable block, three records back to back
    do_reset();
    drv(0, 1'b1, 9'h1B6, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk_out(0, $sformatf("t2_w%0d", k), 1'b0, 0, 0, 1'b0, 1'b0, k);
    end
    for (int c = 0; c < NCH; c++) begin
      step();
      chk_out(0, $sformatf("t2_rec%0d", c), 1'b1, c, 6, 1'b0, 1'b0, 8);
    end
    step();
    chk_out(0, "t2_done", 1'b0, 0, 0, 1'b1, 1'b1, 8);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out(0, $sformatf("t2_sticky%0d", k), 1'b0, 0, 0, 1'b1, 1'b0, 8);
    end

    // T3: info change restarts persistence, then T5: reset with record pending
    do_reset();
    drv(0, 1'b1, 9'h0A5, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_out(0, $sformatf("t3_a%0d", k), 1'b0, 0, 0, 1'b0, 1'b0, k);
    end
    drv(0, 1'b1, 9'h049, 1'b0);
    for (int j = 1; j <= 7; j++) begin
      step();
      chk_out(0, $sformatf("t3_b%0d", j), 1'b0, 0, 0, 1'b0, 1'b0, j);
    end
    step();
    chk_out(0, "t3_decl", 1'b1, 0, 1, 1'b0, 1'b0, 8);
    reset = 1'b1;
    step();
    chk_zero(0, "t5_rst");
    reset = 1'b0;
    drv(0, 1'b0, 9'h049, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_zero(0, $sformatf("t5_after%0d", k));
    end

    // T6: THRESHOLD=1 with all-zero info
    do_reset();
    drv(1, 1'b1, 9'h000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out(1, $sformatf("t6_dump%0d", k), 1'b0, 0, 0, 1'b0, 1'b0, 1);
    end
    step();
    chk_out(1, "t6_done", 1'b0, 0, 0, 1'b1, 1'b1, 1);
    step();
    chk_out(1, "t6_sticky", 1'b0, 0, 0, 1'b1, 1'b0, 1);

    // T4 as a vector table on the THRESHOLD=1 instance
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drv(1, tbl[i].blk, tbl[i].info, tbl[i].rdy);
      step();
      chk_out(1, $sformatf("vec%0d", i), tbl[i].ev, tbl[i].ech, tbl[i].efl,
              tbl[i].efd, tbl[i].efn, tbl[i].ecnt);
    end

    // Random stimulus against the reference model
    do_reset();
    m_reset(0);
    m_reset(1);
    cur_info = rand_info();
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      blk = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 11) == 0) cur_info = rand_info();
      r0 = ($urandom_range(0, 9) < 6);
      r1 = ($urandom_range(0, 9) < 6);
      reset = rst;
      drv(0, blk, cur_info, r0);
      drv(1, blk, cur_info, r1);
      m_step(0, blk, cur_info, r0, rst);
      m_step(1, blk, cur_info, r1, rst);
      step();
      m_check(0, $sformatf("rnd8_%0d", n));
      m_check(1, $sformatf("rnd1_%0d", n));
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
